// File: rtl/aud_dac_player.sv
// ----------------------------------------------------------------------------------------------
// aud_dac_player
//
// I2S transmitter for the WM8731 DAC playback path. 16-bit (DATA_W) PCM words arrive over a
// valid/ready handshake into a one-entry holding register. On every left-channel LRCK edge the
// held word is moved into the shift register and sent MSB-first on o_dacdat, starting one BCLK
// after the LRCK transition (standard I2S delay). The right half repeats the left word
// (BOTH_CH=1) or sends zeros (BOTH_CH=0). After DATA_W bits the line pads with zeros until the
// next LRCK edge.
//
// Ports
//   i_clk         bit clock (AUD_BCLK), rising-edge state
//   i_rst_n       asynchronous active-low reset
//   i_en          playback enable
//   i_daclrck     AUD_DACLRCK from codec (0 = left half, 1 = right half)
//   i_dac_data    sample from playback controller
//   i_dac_valid   i_dac_data valid
//   o_dac_ready   holding register empty and player active
//   o_dacdat      registered serial data to AUD_DACDAT
//   o_sample_req  one-cycle pulse when a left word is loaded
//   o_underrun    one-cycle pulse when a left frame starts with no word held
// ----------------------------------------------------------------------------------------------
module aud_dac_player #(
   parameter int unsigned DATA_W  = 16,
   parameter bit          BOTH_CH = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_daclrck,
   input  logic [DATA_W-1:0] i_dac_data,
   input  logic              i_dac_valid,
   output logic              o_dac_ready,
   output logic              o_dacdat,
   output logic              o_sample_req,
   output logic              o_underrun
);

   localparam int unsigned CntW = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      StIdle,
      StWaitSync,
      StShift,
      StPad
   } state_e;

   state_e              state_q, state_d;
   logic                lrck_q;
   logic                hold_valid_q, hold_valid_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [DATA_W-1:0]   word_q, word_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                dacdat_q, dacdat_d;
   logic                sample_req_q, sample_req_d;
   logic                underrun_q, underrun_d;

   logic                frame_start;
   logic                left_start;
   logic                ready;
   logic                xfer;
   logic                do_start;
   logic [DATA_W-1:0]   start_word;
   logic [CntW-1:0]     cnt_inc;

   // LRCK edge seen this cycle: the next rising edge launches the MSB
   assign frame_start = (i_daclrck != lrck_q);
   assign left_start  = frame_start & ~i_daclrck;

   assign ready   = ~hold_valid_q & (state_q != StIdle);
   assign xfer    = i_dac_valid & ready;
   assign cnt_inc = cnt_q + CntW'(1);

   always_comb begin
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_d       = hold_q;
      word_d       = word_q;
      shift_d      = shift_q;
      cnt_d        = cnt_q;
      dacdat_d     = 1'b0;
      sample_req_d = 1'b0;
      underrun_d   = 1'b0;
      do_start     = 1'b0;
      start_word   = '0;

      // Accepted words wait for the next left frame; no bypass into the shifter
      if (xfer) begin
         hold_valid_d = 1'b1;
         hold_d       = i_dac_data;
      end

      unique case (state_q)
         StIdle: begin
            hold_valid_d = 1'b0;
            shift_d      = '0;
            cnt_d        = '0;
            if (i_en) begin
               state_d = StWaitSync;
            end
         end
         StWaitSync: begin
            // Right-half edges are ignored until the stream aligns on a left word
            if (!i_en) begin
               state_d = StIdle;
            end else if (left_start) begin
               do_start = 1'b1;
            end
         end
         StShift, StPad: begin
            if (frame_start) begin
               // A disable only takes effect at a word boundary
               if (!i_en) begin
                  state_d = StIdle;
                  shift_d = '0;
                  cnt_d   = '0;
               end else begin
                  do_start = 1'b1;
               end
            end else if (state_q == StShift) begin
               dacdat_d = shift_q[DATA_W-1];
               shift_d  = {shift_q[DATA_W-2:0], 1'b0};
               cnt_d    = cnt_inc;
               if (cnt_inc == CntW'(DATA_W)) begin
                  state_d = StPad;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Frame start: pick the word for this half and launch its MSB immediately
      if (do_start) begin
         if (!i_daclrck) begin
            if (hold_valid_q) begin
               start_word   = hold_q;
               hold_valid_d = 1'b0;
               sample_req_d = 1'b1;
            end else begin
               start_word   = '0;
               underrun_d   = 1'b1;
            end
            word_d = start_word;
         end else begin
            start_word = BOTH_CH ? word_q : '0;
         end
         dacdat_d = start_word[DATA_W-1];
         shift_d  = {start_word[DATA_W-2:0], 1'b0};
         cnt_d    = CntW'(1);
         state_d  = StShift;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= StIdle;
         lrck_q       <= 1'b0;
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
         word_q       <= '0;
         shift_q      <= '0;
         cnt_q        <= '0;
         dacdat_q     <= 1'b0;
         sample_req_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         lrck_q       <= i_daclrck;
         hold_valid_q <= hold_valid_d;
         hold_q       <= hold_d;
         word_q       <= word_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         dacdat_q     <= dacdat_d;
         sample_req_q <= sample_req_d;
         underrun_q   <= underrun_d;
      end
   end

   assign o_dac_ready  = ready;
   assign o_dacdat     = dacdat_q;
   assign o_sample_req = sample_req_q;
   assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_aud_dac_player.sv
// ----------------------------------------------------------------------------------------------
// tb_aud_dac_player
//
// Bench for aud_dac_player (DATA_W=16, BOTH_CH=1). A frame-level model (word queue, bit
// position within the current LRCK half) predicts every output each cycle; directed scenarios
// add hand-computed literal expectations on captured serial words and pulses.
// ----------------------------------------------------------------------------------------------
module tb_aud_dac_player;

   localparam int DW   = 16;
   localparam bit BOTH = 1'b1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          lrck = 1'b0;
   logic [DW-1:0] data = '0;
   logic          valid = 1'b0;
   logic          dac_ready;
   logic          dacdat;
   logic          sample_req;
   logic          underrun;

   aud_dac_player #(
      .DATA_W  (DW),
      .BOTH_CH (BOTH)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_en         (en),
      .i_daclrck    (lrck),
      .i_dac_data   (data),
      .i_dac_valid  (valid),
      .o_dac_ready  (dac_ready),
      .o_dacdat     (dacdat),
      .o_sample_req (sample_req),
      .o_underrun   (underrun)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Codec LRCK: toggles every lrck_half BCLKs, driven on the falling edge
   bit lrck_run  = 1'b1;
   int lrck_half = 20;
   int lrck_cnt  = 0;

   always @(negedge clk) begin
      if (lrck_run) begin
         if (lrck_cnt >= lrck_half - 1) begin
            lrck     = ~lrck;
            lrck_cnt = 0;
         end else begin
            lrck_cnt++;
         end
      end
   end

   // Frame-level model
   int            m_mode = 0;   // 0 idle, 1 waiting for left edge, 2 streaming
   logic          m_prev = 1'b0;
   logic [DW-1:0] m_word = '0;
   logic [DW-1:0] m_left_word = '0;
   int            m_pos = DW;
   logic [DW-1:0] m_hold[$];
   logic          m_ready = 1'b0;
   logic          m_dat = 1'b0;
   logic          m_req = 1'b0;
   logic          m_und = 1'b0;
   int            m_left_cnt = 0;
   int            m_right_cnt = 0;

   task automatic start_frame();
      if (!lrck) begin
         if (m_hold.size() > 0) begin
            m_word = m_hold.pop_front();
            m_req  = 1'b1;
         end else begin
            m_word = '0;
            m_und  = 1'b1;
         end
         m_left_word = m_word;
      end else begin
         m_word = BOTH ? m_left_word : '0;
      end
      m_pos  = 1;
      m_dat  = m_word[DW-1];
      m_mode = 2;
   endtask

   always @(posedge clk) begin
      bit fs;
      bit xfer;
      if (!rst_n) begin
         m_mode = 0;
         m_prev = 1'b0;
         m_word = '0;
         m_left_word = '0;
         m_pos = DW;
         m_hold.delete();
         m_ready = 1'b0;
         m_dat = 1'b0;
         m_req = 1'b0;
         m_und = 1'b0;
      end else begin
         fs     = (lrck != m_prev);
         m_prev = lrck;
         xfer   = valid && m_ready;
         m_dat  = 1'b0;
         m_req  = 1'b0;
         m_und  = 1'b0;
         if (fs) begin
            if (lrck) m_right_cnt++;
            else      m_left_cnt++;
         end
         if (m_mode == 0) begin
            m_hold.delete();
            if (en) m_mode = 1;
         end else if (m_mode == 1) begin
            if (!en) m_mode = 0;
            else if (fs && !lrck) start_frame();
         end else begin
            if (fs) begin
               if (!en) m_mode = 0;
               else start_frame();
            end else if (m_pos < DW) begin
               m_dat = m_word[DW-1-m_pos];
               m_pos++;
            end
         end
         if (xfer) m_hold.push_back(data);
         m_ready = (m_mode != 0) && (m_hold.size() == 0);
      end
      #1;
      check("model_dacdat", 32'(dacdat), 32'(m_dat));
      check("model_ready", 32'(dac_ready), 32'(m_ready));
      check("model_sample_req", 32'(sample_req), 32'(m_req));
      check("model_underrun", 32'(underrun), 32'(m_und));
   end

   // Directed helpers: sample point is 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_left();
      int start;
      start = m_left_cnt;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_left_cnt != start) return;
      end
      check("wait_left_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_right();
      int start;
      start = m_right_cnt;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (m_right_cnt != start) return;
      end
      check("wait_right_timeout", 32'd0, 32'd1);
   endtask

   // First bit is taken at the current sample point (frame start)
   task automatic capture(input int n, output logic [31:0] v);
      v = '0;
      for (int k = 0; k < n; k++) begin
         if (k > 0) tick();
         v = {v[30:0], dacdat};
      end
   endtask

   logic [31:0] cap;
   int          pulses;
   int          ones;
   int          rc;

   initial begin
      // Reset, disabled, LRCK toggling
      tick();
      tick();
      check("reset_dacdat", 32'(dacdat), 32'd0);
      check("reset_ready", 32'(dac_ready), 32'd0);
      check("reset_sample_req", 32'(sample_req), 32'd0);
      check("reset_underrun", 32'(underrun), 32'd0);
      rst_n = 1'b1;
      pulses = 0;
      ones = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         pulses += int'(sample_req) + int'(underrun) + int'(dac_ready);
         ones += int'(dacdat);
      end
      check("idle_pulses_ready", 32'(pulses), 32'd0);
      check("idle_dacdat_ones", 32'(ones), 32'd0);

      // Word A5C3 offered before the first left edge
      lrck_run = 1'b0;
      lrck = 1'b1;
      lrck_half = 32;
      tick();
      tick();
      en = 1'b1;
      tick();
      check("ready_after_enable", 32'(dac_ready), 32'd1);
      valid = 1'b1;
      data = 16'hA5C3;
      tick();
      valid = 1'b0;
      check("ready_after_xfer", 32'(dac_ready), 32'd0);
      lrck_cnt = 0;
      lrck_run = 1'b1;
      wait_left();
      check("a5c3_sample_req", 32'(sample_req), 32'd1);
      check("a5c3_underrun", 32'(underrun), 32'd0);
      capture(DW, cap);
      check("a5c3_left_bits", cap, 32'h0000_A5C3);
      tick();
      check("a5c3_pad", 32'(dacdat), 32'd0);
      wait_right();
      capture(DW, cap);
      check("a5c3_right_bits", cap, 32'h0000_A5C3);

      // Nothing held at next left edge
      wait_left();
      check("underrun_pulse", 32'(underrun), 32'd1);
      check("underrun_no_req", 32'(sample_req), 32'd0);
      capture(DW, cap);
      check("underrun_left_zero", cap, 32'd0);
      wait_right();
      capture(DW, cap);
      check("underrun_right_zero", cap, 32'd0);

      // Valid arrives exactly on the left-edge cycle
      rc = 0;
      while (!(lrck == 1'b1 && lrck_cnt == lrck_half - 1) && rc < 200) begin
         tick();
         rc++;
      end
      valid = 1'b1;
      data = 16'h1234;
      tick();
      valid = 1'b0;
      check("late_valid_underrun", 32'(underrun), 32'd1);
      check("late_valid_accepted", 32'(dac_ready), 32'd0);
      wait_left();
      check("late_valid_req_next", 32'(sample_req), 32'd1);
      capture(DW, cap);
      check("late_valid_bits", cap, 32'h0000_1234);

      // Short LRCK half-period truncates the word
      lrck_half = 8;
      wait_left();
      valid = 1'b1;
      data = 16'hFFFF;
      tick();
      valid = 1'b0;
      wait_left();
      check("short_req", 32'(sample_req), 32'd1);
      rc = m_right_cnt;
      capture(8, cap);
      check("short_left_bits", cap, 32'h0000_00FF);
      tick();
      check("short_right_edge", 32'(m_right_cnt - rc), 32'd1);
      check("short_right_msb", 32'(dacdat), 32'd1);

      // Enable dropped mid left word
      lrck_half = 32;
      wait_left();
      valid = 1'b1;
      data = 16'h8001;
      tick();
      valid = 1'b0;
      wait_left();
      cap = '0;
      for (int k = 0; k < DW; k++) begin
         if (k > 0) tick();
         if (k == 4) en = 1'b0;
         cap = {cap[30:0], dacdat};
      end
      check("endrop_bits", cap, 32'h0000_8001);
      wait_right();
      check("endrop_idle_dacdat", 32'(dacdat), 32'd0);
      check("endrop_idle_ready", 32'(dac_ready), 32'd0);
      for (int i = 0; i < 10; i++) tick();

      // Reset in the middle of a word
      wait_right();
      en = 1'b1;
      tick();
      valid = 1'b1;
      data = 16'hFFFF;
      tick();
      valid = 1'b0;
      wait_left();
      tick();
      tick();
      tick();
      check("pre_reset_dacdat", 32'(dacdat), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midreset_dacdat", 32'(dacdat), 32'd0);
      check("midreset_ready", 32'(dac_ready), 32'd0);
      check("midreset_sample_req", 32'(sample_req), 32'd0);
      check("midreset_underrun", 32'(underrun), 32'd0);
      tick();
      tick();
      tick();
      en = 1'b0;
      rst_n = 1'b1;
      ones = 0;
      for (int i = 0; i < 60; i++) begin
         tick();
         ones += int'(dacdat);
      end
      check("post_reset_quiet", 32'(ones), 32'd0);
      en = 1'b1;
      for (int i = 0; i < 150; i++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
